// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one negedge-sampled block RAM between instruction fetch and load/store.
// Optional round-robin arbitration when MEM_ARB_RR_EN is defined; fixed data-over-fetch priority otherwise.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Handshake: a requester holds req and payload until its gnt pulse, and drops or
    // replaces them by the posedge ending that gnt cycle; payload is sampled only at
    // the arbitration posedge (in IDLE, or at the end of RESP).
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  sel_d_q, sel_d_d;
    logic                  we_q, we_d;
    logic                  oor_q, oor_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic                  pick_d;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_we;
    logic                  win_oor;

`ifdef MEM_ARB_RR_EN
    logic last_d_q, last_d_d;
    assign pick_d = d_req & (~if_req | ~last_d_q);
`else
    assign pick_d = d_req;
`endif

    assign win_addr = pick_d ? d_addr : if_addr;
    assign win_we   = pick_d & d_we;
    assign win_oor  = (win_addr >= ADDR_WIDTH'(DEPTH));

    always_comb begin
        state_d     = state_q;
        sel_d_d     = sel_d_q;
        we_d        = we_q;
        oor_d       = oor_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        unique case (state_q)
            IDLE, RESP: begin
                if (if_req || d_req) begin
                    state_d     = ISSUE;
                    sel_d_d     = pick_d;
                    we_d        = win_we;
                    oor_d       = win_oor;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = pick_d ? d_wdata : mem_wdata_q;
                    // Write enable is a flop so it is high for exactly the ISSUE cycle.
                    mem_write_d = win_we & ~win_oor;
`ifdef MEM_ARB_RR_EN
                    last_d_d    = pick_d;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = RESP;
                if (!we_q) begin
                    if (sel_d_q) d_rdata_d  = oor_q ? '0 : mem_rdata;
                    else         if_rdata_d = oor_q ? '0 : mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_d_q     <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_d_q     <= sel_d_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign if_gnt    = (state_q == ISSUE) & ~sel_d_q;
    assign d_gnt     = (state_q == ISSUE) & sel_d_q;
    assign if_rvalid = (state_q == RESP) & ~sel_d_q;
    assign d_rvalid  = (state_q == RESP) & sel_d_q;
    assign err       = (state_q == RESP) & oor_q;
    assign busy      = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized two-port traffic
// checked by per-port expected queues against a memory/arbitration reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          err, busy;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          if_q[$];
    exp_t          d_q[$];
    logic [DW-1:0] mdl[DEPTH];
    logic [DW-1:0] ram[DEPTH];
    logic [DW-1:0] last_d = '0;
    bit            lg_d = 1'b0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .err(err), .busy(busy),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Clock / reset timeout
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Single-port block RAM sampled on the negedge, read-first
    always @(negedge clk) begin
        if (mem_addr < AW'(DEPTH)) begin
            if (mem_write) ram[mem_addr[5:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[5:0]];
        end else begin
            mem_rdata <= '0;
        end
    end

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Reference model: memory image plus per-port response order
    function automatic void push_exp(input bit is_d, input bit we, input logic [AW-1:0] addr,
                                     input logic [DW-1:0] wdata);
        exp_t e;
        bit   oor;
        oor = (addr >= AW'(DEPTH));
        e.err = oor;
        if (is_d && we) begin
            if (!oor) mdl[addr[5:0]] = wdata;
            e.rdata = last_d;
        end else begin
            e.rdata = oor ? '0 : mdl[addr[5:0]];
            if (is_d) last_d = e.rdata;
        end
        if (is_d) d_q.push_back(e);
        else      if_q.push_back(e);
    endfunction

    // Monitor: pops expected responses on every rvalid
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_rvalid) begin
                if (if_q.size() == 0) check("if_unexpected_rvalid", 1, 0);
                else begin
                    exp_t e;
                    e = if_q.pop_front();
                    check("if_rdata", if_rdata, e.rdata);
                    check("if_err", {31'b0, err}, {31'b0, e.err});
                end
            end
            if (d_rvalid) begin
                if (d_q.size() == 0) check("d_unexpected_rvalid", 1, 0);
                else begin
                    exp_t e;
                    e = d_q.pop_front();
                    check("d_rdata", d_rdata, e.rdata);
                    check("d_err", {31'b0, err}, {31'b0, e.err});
                end
            end
            if (err && !if_rvalid && !d_rvalid) check("err_without_rvalid", 1, 0);
            if (if_gnt && d_gnt) check("double_gnt", 1, 0);
        end
    end

    // Driver tasks
    task automatic txn(input bit is_d, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        push_exp(is_d, we, addr, wdata);
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else begin if_req = 1; if_addr = addr; end
        @(negedge clk);
        check("gnt_latency", {31'b0, (is_d ? d_gnt : if_gnt)}, 1);
        check("busy_issue", {31'b0, busy}, 1);
        check("mem_write_issue", {31'b0, mem_write}, {31'b0, (is_d && we && addr < AW'(DEPTH))});
        d_req = 0; if_req = 0;
        lg_d = is_d;
        @(negedge clk);
        check("rvalid_latency", {31'b0, (is_d ? d_rvalid : if_rvalid)}, 1);
        check("busy_resp", {31'b0, busy}, 1);
        check("mem_write_resp", {31'b0, mem_write}, 0);
        @(negedge clk);
        check("busy_idle", {31'b0, busy}, 0);
    endtask

    task automatic wait_gnt(input bit is_d, input string name);
        int w;
        w = 0;
        @(negedge clk);
        while (!(is_d ? d_gnt : if_gnt) && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) check(name, 0, 1);
    endtask

    task automatic run_d(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            logic [AW-1:0] a;
            bit we;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                d_req = 0;
                repeat (gap) @(negedge clk);
            end
            a  = ($urandom_range(0, 9) == 0) ? AW'(64 + $urandom_range(0, 40)) : AW'(32 + $urandom_range(0, 31));
            we = $urandom_range(0, 1) == 1;
            d_we = we; d_addr = a; d_wdata = $urandom; d_req = 1;
            push_exp(1, we, a, d_wdata);
            wait_gnt(1, "d_gnt_timeout");
        end
        d_req = 0;
    endtask

    task automatic run_if(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            logic [AW-1:0] a;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                if_req = 0;
                repeat (gap) @(negedge clk);
            end
            a = ($urandom_range(0, 7) == 0) ? AW'(100 + $urandom_range(0, 50)) : AW'($urandom_range(0, 31));
            if_addr = a; if_req = 1;
            push_exp(0, 0, a, '0);
            wait_gnt(0, "if_gnt_timeout");
        end
        if_req = 0;
    endtask

    initial begin
        bit plan[4];
        logic [DW-1:0] old3;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = $urandom;
            mdl[i] = ram[i];
        end
        ram[5] = 32'hDEADBEEF;
        mdl[5] = 32'hDEADBEEF;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_mem_write", {31'b0, mem_write}, 0);
        check("rst_gnts", {30'b0, if_gnt, d_gnt}, 0);
        check("rst_rvalids", {30'b0, if_rvalid, d_rvalid}, 0);
        check("rst_rdata", if_rdata | d_rdata, 0);
        rst_n = 1;
        @(negedge clk);

        // Contention: data wins first, fetch follows at the next arbitration point
        push_exp(1, 0, 2, '0);
        push_exp(0, 0, 1, '0);
        d_req = 1; d_we = 0; d_addr = 2; if_req = 1; if_addr = 1;
        @(negedge clk);
        check("cont_c1_gnt", {30'b0, d_gnt, if_gnt}, 2'b10);
        d_req = 0;
        @(negedge clk);
        check("cont_c2_d_rvalid", {31'b0, d_rvalid}, 1);
        @(negedge clk);
        check("cont_c3_gnt", {30'b0, d_gnt, if_gnt}, 2'b01);
        if_req = 0;
        @(negedge clk);
        check("cont_c4_if_rvalid", {31'b0, if_rvalid}, 1);
        lg_d = 0;
        @(negedge clk);

        // Both ports requesting continuously
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            plan[k] = !lg_d;
`else
            plan[k] = 1'b1;
`endif
            lg_d = plan[k];
            push_exp(plan[k], 0, plan[k] ? 40 : 7, '0);
        end
        d_req = 1; d_we = 0; d_addr = 40; if_req = 1; if_addr = 7;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("alt_gnt", {30'b0, d_gnt, if_gnt}, plan[k] ? 2'b10 : 2'b01);
            if (k == 3) begin d_req = 0; if_req = 0; end
            @(negedge clk);
        end
        @(negedge clk);

        // Single fetch, data write/read, out of range
        txn(0, 0, 5, '0);
        check("fetch_deadbeef", if_rdata, 32'hDEADBEEF);
        txn(1, 1, 10, 32'h12345678);
        check("ram_written", ram[10], 32'h12345678);
        txn(1, 0, 10, '0);
        check("d_readback", d_rdata, 32'h12345678);
        txn(1, 1, 64, 32'hA5A5A5A5);
        check("oor_ram0_unchanged", ram[0], mdl[0]);
        txn(0, 0, 100, '0);

        // Reset during ISSUE of a write
        old3 = ram[3];
        d_req = 1; d_we = 1; d_addr = 3; d_wdata = ~old3;
        @(posedge clk);
        #1;
        check("rst_mid_gnt", {31'b0, d_gnt}, 1);
        check("rst_mid_mem_write_before", {31'b0, mem_write}, 1);
        rst_n = 0;
        d_req = 0;
        #1;
        check("rst_mid_mem_write", {31'b0, mem_write}, 0);
        check("rst_mid_busy", {31'b0, busy}, 0);
        @(negedge clk);
        #1;
        check("rst_mid_ram3", ram[3], old3);
        @(negedge clk);
        rst_n = 1;
        last_d = '0;
        lg_d = 0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_quiet", {26'b0, busy, mem_write, d_rvalid, if_rvalid, d_gnt, if_gnt}, 0);
            check("post_rst_rdata", if_rdata | d_rdata | mem_addr | mem_wdata, 0);
        end

        // Randomized two-port traffic
        fork
            run_d(40);
            run_if(40);
        join
        repeat (4) @(negedge clk);
        check("drain_if_q", if_q.size(), 0);
        check("drain_d_q", d_q.size(), 0);
        check("drain_busy", {31'b0, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
